// File: rtl/wc_tile_seq.sv
// Tile sequencer for the Winograd F(4,3) core: builds stride-4 six-sample windows,
// tracks in-flight tiles and buffers results. Optional stall counter: WC_SEQ_PERF_EN.
module wc_tile_seq #(
    parameter int DW         = 10,
    parameter int CORE_LAT   = 6,
    parameter int LEN_W      = 12,
    parameter int OBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  n_tiles,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    output logic              s_ready,
    output logic [6*DW-1:0]   core_d,
    input  logic [4*DW-1:0]   core_z,
    output logic              m_valid,
    output logic [4*DW-1:0]   m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
`ifdef WC_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam logic [CW:0]      DEPTH_C  = (CW+1)'(OBUF_DEPTH);
    localparam logic [PW-1:0]    LAST_PTR = PW'(OBUF_DEPTH - 1);
    localparam logic [PW-1:0]    ONE_P    = PW'(1);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          need_q;
    logic [DW-1:0]       win_q [6];
    logic [6*DW-1:0]     win_flat;
    logic [LEN_W-1:0]    n_tiles_q, issued_q, retired_q;
    logic [CORE_LAT-1:0] tok_q;
    logic [CW-1:0]       inflight_q, fifo_cnt_q;
    logic [4*DW-1:0]     fifo_data_q [OBUF_DEPTH];
    logic                fifo_last_q [OBUF_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [6*DW-1:0]     core_d_q;
    logic                done_q;

    logic credit, issue, accept, retire, pop, last_pop, start_go, start_zero;

    // Credit counts both buffered and still-in-core tiles so a retire can never hit a full FIFO.
    assign credit     = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < DEPTH_C;
    assign issue      = (state_q == S_ISSUE) && credit;
    assign accept     = s_valid && s_ready;
    assign retire     = tok_q[CORE_LAT-1];
    assign pop        = m_valid && m_ready;
    assign last_pop   = pop && fifo_last_q[rd_ptr_q];
    assign start_go   = (state_q == S_IDLE) && start && (n_tiles != '0);
    assign start_zero = (state_q == S_IDLE) && start && (n_tiles == '0);

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < 6; i++) win_flat[(5-i)*DW +: DW] = win_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = S_FILL;
            S_FILL:  if (accept && need_q == 3'd1) state_d = S_ISSUE;
            S_ISSUE: if (issue) state_d = (issued_q + ONE_L == n_tiles_q) ? S_DRAIN : S_FILL;
            S_DRAIN: if (last_pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_FILL:           begin s_ready = 1'b1; busy = 1'b1; end
            S_ISSUE, S_DRAIN: busy = 1'b1;
            default:          ;
        endcase
    end

    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = m_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign m_last  = m_valid && fifo_last_q[rd_ptr_q];
    assign core_d  = core_d_q;
    assign done    = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            need_q     <= '0;
            for (int i = 0; i < 6; i++) win_q[i] <= '0;
            n_tiles_q  <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            tok_q      <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            core_d_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= start_zero || ((state_q == S_DRAIN) && last_pop);
            if (start_go) begin
                n_tiles_q <= n_tiles;
                issued_q  <= '0;
                retired_q <= '0;
                need_q    <= 3'd6;
            end
            if (accept) begin
                win_q[3'd6 - need_q] <= s_data;
                need_q               <= need_q - 3'd1;
            end
            // Slots 4,5 become the 2-sample overlap of the next window.
            if (issue) begin
                core_d_q <= win_flat;
                issued_q <= issued_q + ONE_L;
                win_q[0] <= win_q[4];
                win_q[1] <= win_q[5];
                need_q   <= 3'd4;
            end
            tok_q <= {tok_q[CORE_LAT-2:0], issue};
            case ({issue, retire})
                2'b10:   inflight_q <= inflight_q + ONE_C;
                2'b01:   inflight_q <= inflight_q - ONE_C;
                default: ;
            endcase
            if (retire) begin
                fifo_data_q[wr_ptr_q] <= core_z;
                fifo_last_q[wr_ptr_q] <= (retired_q == n_tiles_q - ONE_L);
                wr_ptr_q              <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ONE_P;
                retired_q             <= retired_q + ONE_L;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ONE_P;
            case ({retire, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + ONE_C;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - ONE_C;
                default: ;
            endcase
        end
    end

`ifdef WC_SEQ_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if ((state_q == S_IDLE) && start)
            stall_q <= '0;
        else if ((state_q == S_ISSUE) && !credit && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wc_tile_seq.sv
// Directed bench for wc_tile_seq with a fixed-latency stand-in core (3-tap filter 1,2,-1).
// Build with WC_SEQ_PERF_EN to also check the stall counter.
module tb_wc_tile_seq;
    localparam int DW = 10;
    localparam int CORE_LAT = 6;
    localparam int LEN_W = 12;
    localparam int OBUF_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  n_tiles = '0;
    logic              s_valid = 1'b0;
    logic [DW-1:0]     s_data = '0;
    logic              s_ready;
    logic [6*DW-1:0]   core_d;
    logic [4*DW-1:0]   core_z;
    logic              m_valid;
    logic [4*DW-1:0]   m_data;
    logic              m_last;
    logic              m_ready = 1'b1;
    logic              busy;
    logic              done;
`ifdef WC_SEQ_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    int tests = 0, fails = 0;
    int cyc = 0, acc_cnt = 0, sready_cnt = 0, done_cnt = 0, issue_cnt = 0, tiles_out = 0;
    int done_cyc = 0, last_pop_cyc = 0;
    logic [6*DW-1:0] prev_core_d = '0;
    logic [4*DW:0]   exp_q[$];
    int              smp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wc_tile_seq #(.DW(DW), .CORE_LAT(CORE_LAT), .LEN_W(LEN_W), .OBUF_DEPTH(OBUF_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .n_tiles(n_tiles),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_d(core_d), .core_z(core_z),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done)
`ifdef WC_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [4*DW-1:0] core_fn(input logic [6*DW-1:0] d);
        logic signed [DW-1:0] s [6];
        logic [4*DW-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) s[i] = d[(5-i)*DW +: DW];
        for (int k = 0; k < 4; k++) r[(3-k)*DW +: DW] = DW'(s[k] + 2 * s[k+1] - s[k+2]);
        return r;
    endfunction

    function automatic logic [6*DW-1:0] pack6(input int a, b, c, d, e, f);
        return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f)};
    endfunction

    function automatic logic [4*DW-1:0] pack4(input int a, b, c, d);
        return {DW'(a), DW'(b), DW'(c), DW'(d)};
    endfunction

    // Core stand-in: result for a core_d update is sampled at the CORE_LAT-th edge after it.
    logic [4*DW-1:0] pipe [CORE_LAT-1];
    always @(posedge clk) begin
        pipe[0] <= core_fn(core_d);
        for (int i = 1; i < CORE_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_z = pipe[CORE_LAT-2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor and scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) acc_cnt++;
            if (s_ready) sready_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (core_d !== prev_core_d) issue_cnt++;
            if (m_valid && m_ready) begin
                tiles_out++;
                if (m_last) last_pop_cyc = cyc;
                check("sb_tile_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("sb_tile", {m_last, m_data}, exp_q.pop_front());
            end
        end
        prev_core_d = core_d;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        n_tiles = LEN_W'(n);
        step(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] x, input bit gap);
        int guard = 0;
        bit acc = 1'b0;
        s_valid = 1'b1;
        s_data = x;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        if (gap) step(1);
    endtask

    task automatic send_range(input int lo, input int hi, input bit gap);
        for (int i = lo; i < hi; i++) send(DW'(smp[i]), gap);
    endtask

    task automatic push_exp(input int n);
        logic [6*DW-1:0] w;
        for (int t = 0; t < n; t++) begin
            for (int j = 0; j < 6; j++) w[(5-j)*DW +: DW] = DW'(smp[4*t+j]);
            exp_q.push_back({(t == n - 1), core_fn(w)});
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int base = done_cnt;
        int g = 0;
        while (done_cnt == base && g < bound) begin
            step(1);
            g++;
        end
        check(tag, 64'(done_cnt != base), 64'd1);
    endtask

    int acc_b, done_b, iss_b, tile_b, sr_b;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_core_d", core_d, 0);
        check("rst_m_data", {m_last, m_data}, 0);
        step(1);
        rst = 1'b0;

        // Single tile
        acc_b = acc_cnt; done_b = done_cnt; tile_b = tiles_out;
        smp = '{2, -10, 3, 4, -13, -18};
        exp_q.push_back({1'b1, pack4(-21, -8, 24, -4)});
        do_start(1);
        check("t1_busy", busy, 1);
        send_range(0, 6, 0);
        wait_done("t1_done_timeout", 100);
        step(3);
        check("t1_core_d", core_d, pack6(2, -10, 3, 4, -13, -18));
        check("t1_accepted", acc_cnt - acc_b, 6);
        check("t1_tiles", tiles_out - tile_b, 1);
        check("t1_done_count", done_cnt - done_b, 1);
        check("t1_done_latency", done_cyc - last_pop_cyc, 1);
        check("t1_idle", busy, 0);

        // Overlap, with a start pulse mid-run that must be ignored
        acc_b = acc_cnt; done_b = done_cnt; tile_b = tiles_out;
        smp = '{2, -10, 3, 4, -13, -18, -19, -6, 3, -9};
        push_exp(2);
        do_start(2);
        send_range(0, 3, 0);
        start = 1'b1; n_tiles = 12'd7;
        send_range(3, 4, 0);
        start = 1'b0;
        send_range(4, 10, 0);
        step(1);
        @(negedge clk);
        check("ov_core_d2", core_d, pack6(-13, -18, -19, -6, 3, -9));
        check("ov_s_ready_low", s_ready, 0);
        wait_done("ov_done_timeout", 100);
        step(3);
        check("ov_accepted", acc_cnt - acc_b, 10);
        check("ov_tiles", tiles_out - tile_b, 2);
        check("ov_done_count", done_cnt - done_b, 1);

        // Continuous then sparse input over the same samples
        smp = '{7, -3, 12, 0, -25, 9, 31, -8, 4, 15, -40, 22, 6, -1};
        for (int pass = 0; pass < 2; pass++) begin
            acc_b = acc_cnt; tile_b = tiles_out;
            push_exp(3);
            do_start(3);
            send_range(0, 14, pass[0]);
            wait_done(pass == 0 ? "cont_done_timeout" : "sparse_done_timeout", 150);
            step(2);
            check(pass == 0 ? "cont_tiles" : "sparse_tiles", tiles_out - tile_b, 3);
            check(pass == 0 ? "cont_accepted" : "sparse_accepted", acc_cnt - acc_b, 14);
        end

        // Backpressure
        smp = {};
        for (int i = 0; i < 34; i++) smp.push_back(100 + 5 * i);
        acc_b = acc_cnt; done_b = done_cnt; iss_b = issue_cnt; tile_b = tiles_out;
        m_ready = 1'b0;
        push_exp(8);
        do_start(8);
        send_range(0, 22, 0);
        step(40);
        @(negedge clk);
        check("bp_issued", issue_cnt - iss_b, OBUF_DEPTH);
        check("bp_s_ready", s_ready, 0);
        check("bp_fifo_cnt", dut.fifo_cnt_q, OBUF_DEPTH);
        check("bp_m_valid", m_valid, 1);
`ifdef WC_SEQ_PERF_EN
        check("bp_stall_cnt", stall_cnt, 40);
`endif
        step(1);
        m_ready = 1'b1;
        send_range(22, 34, 0);
        wait_done("bp_done_timeout", 300);
        step(5);
        check("bp_tiles", tiles_out - tile_b, 8);
        check("bp_accepted", acc_cnt - acc_b, 34);
        check("bp_done_count", done_cnt - done_b, 1);
        check("bp_sb_empty", 64'(exp_q.size()), 0);

        // Reset mid-run with two tiles in flight
        smp = '{2, -10, 3, 4, -13, -18, -19, -6, 3, -9};
        m_ready = 1'b0;
        do_start(3);
        send_range(0, 10, 0);
        step(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mr_m_valid", m_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_core_d", core_d, 0);
        check("mr_s_ready", s_ready, 0);
        step(1);
        rst = 1'b0;
        m_ready = 1'b1;
        done_b = done_cnt; tile_b = tiles_out;
        step(10);
        check("mr_no_done", done_cnt - done_b, 0);
        check("mr_no_tiles", tiles_out - tile_b, 0);
        smp = '{5, 6, -7, 8, -9, 10};
        push_exp(1);
        do_start(1);
        send_range(0, 6, 0);
        wait_done("mr_fresh_done_timeout", 100);
        step(2);
        check("mr_fresh_tiles", tiles_out - tile_b, 1);

        // Zero-length run
        done_b = done_cnt; sr_b = sready_cnt;
        do_start(0);
        step(5);
        check("z_done_count", done_cnt - done_b, 1);
        check("z_s_ready_never", sready_cnt - sr_b, 0);
        check("z_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
